fetch_stage_ctrl: RTL and testbench

- Responder to the pipeline hazard unit. Owns the PC register and the IF/ID pipeline register, and obeys the unit's stall and flush requests.
- Computes the next PC (sequential, or redirect on jump/branch) and captures the fetched instruction into IF/ID. It inserts NOP bubbles on flush and freezes on stall.
- Runs a small run-control FSM (IDLE/RUN/HALT) with a debug single-step mode. Sits between instruction memory and the decode stage.

---
 rtl/fetch_stage_ctrl_if.sv | 31 +++
 rtl/fetch_stage_ctrl.sv | 102 ++++++++++
 tb/tb_fetch_stage_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_ctrl_if.sv
// Fetch-stage bus: run control, hazard requests and instruction memory on the
// master side; PC and IF/ID contents on the slave (fetch stage) side.
interface fetch_stage_ctrl_if #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 32
);
  logic               i_start;
  logic               i_step_mode;
  logic               i_step;
  logic               i_stall;
  logic               i_flush;
  logic               i_pc_src;
  logic [NB_ADDR-1:0] i_target;
  logic [NB_DATA-1:0] i_instr;
  logic [NB_ADDR-1:0] o_pc;
  logic [NB_DATA-1:0] o_instr_id;
  logic [NB_ADDR-1:0] o_pc_plus4_id;
  logic               o_valid_id;
  logic               o_halted;
  logic [1:0]         o_state;

  modport master (
    output i_start, i_step_mode, i_step, i_stall, i_flush, i_pc_src, i_target, i_instr,
    input  o_pc, o_instr_id, o_pc_plus4_id, o_valid_id, o_halted, o_state
  );

  modport slave (
    input  i_start, i_step_mode, i_step, i_stall, i_flush, i_pc_src, i_target, i_instr,
    output o_pc, o_instr_id, o_pc_plus4_id, o_valid_id, o_halted, o_state
  );
endinterface

// File: rtl/fetch_stage_ctrl.sv
// Instruction fetch stage: PC register, IF/ID register and IDLE/RUN/HALT run
// control with debug single-step. Obeys hazard-unit stall/flush requests.
module fetch_stage_ctrl #(
  parameter int unsigned        NB_DATA    = 32,
  parameter int unsigned        NB_ADDR    = 32,
  parameter logic [NB_ADDR-1:0] RESET_PC   = '0,
  parameter logic [NB_DATA-1:0] HALT_INSTR = '1
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  fetch_stage_ctrl_if.slave    fetch_io
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NB_ADDR-1:0] pc_q, pc_d;
  logic [NB_DATA-1:0] instr_q, instr_d;
  logic [NB_ADDR-1:0] pc4_q, pc4_d;
  logic               valid_q, valid_d;

  logic [NB_ADDR-1:0] pc_seq;
  logic               adv;

  // Sequential PC wraps naturally in NB_ADDR bits.
  assign pc_seq = pc_q + NB_ADDR'(4);
  assign adv    = (state_q == StRun) && (!fetch_io.i_step_mode || fetch_io.i_step);

  // Next-state: run control FSM, PC selection and IF/ID capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (state_q)
      StIdle: begin
        if (fetch_io.i_start) state_d = StRun;
      end
      StRun: begin
        // A stalled cycle drops flush/redirect/halt; the hazard unit re-asserts them.
        if (adv && !fetch_io.i_stall) begin
          pc_d = fetch_io.i_pc_src ? fetch_io.i_target : pc_seq;
          if (fetch_io.i_flush) begin
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
          end else if (fetch_io.i_instr == HALT_INSTR) begin
            // Halt pins the PC on the halting instruction, ignoring any redirect.
            pc_d    = pc_q;
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
            state_d = StHalt;
          end else begin
            instr_d = fetch_io.i_instr;
            pc4_d   = pc_seq;
            valid_d = 1'b1;
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    fetch_io.o_pc          = pc_q;
    fetch_io.o_instr_id    = instr_q;
    fetch_io.o_pc_plus4_id = pc4_q;
    fetch_io.o_valid_id    = valid_q;
    fetch_io.o_halted      = (state_q == StHalt);
    fetch_io.o_state       = state_q;
  end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Bench for fetch_stage_ctrl: directed vector table, randomized run against a
// reference model, and a PC wrap check on a second instance.
module tb_fetch_stage_ctrl;

  localparam logic [31:0] Halt = 32'hFFFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_n_w;
  logic force_halt;

  fetch_stage_ctrl_if #(.NB_DATA(32), .NB_ADDR(32)) bus ();
  fetch_stage_ctrl_if #(.NB_DATA(32), .NB_ADDR(32)) bus_w ();

  fetch_stage_ctrl #(
    .NB_DATA(32), .NB_ADDR(32), .RESET_PC(32'h0), .HALT_INSTR(Halt)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .fetch_io (bus)
  );

  fetch_stage_ctrl #(
    .NB_DATA(32), .NB_ADDR(32), .RESET_PC(32'hFFFFFFFC), .HALT_INSTR(Halt)
  ) dut_w (
    .i_clk    (clk),
    .i_rst_n  (rst_n_w),
    .fetch_io (bus_w)
  );

  // Instruction memory image; never produces the halt encoding by itself.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h20080001 + (a << 8);
  endfunction

  always_comb bus.i_instr   = force_halt ? Halt : mem_word(bus.o_pc);
  always_comb bus_w.i_instr = mem_word(bus_w.o_pc);

  typedef struct {
    logic        rst_n;
    logic        start;
    logic        smode;
    logic        step;
    logic        stall;
    logic        flush;
    logic        pc_src;
    logic [31:0] target;
    logic        fh;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_st;

  function automatic vec_t mk(
    input logic r, input logic st, input logic sm, input logic sp, input logic sl,
    input logic fl, input logic ps, input logic [31:0] tg, input logic fh,
    input logic [31:0] epc, input logic [31:0] ein, input logic [31:0] ep4,
    input logic ev, input logic [1:0] es);
    vec_t v;
    v.rst_n = r; v.start = st; v.smode = sm; v.step = sp; v.stall = sl;
    v.flush = fl; v.pc_src = ps; v.target = tg; v.fh = fh;
    v.e_pc = epc; v.e_instr = ein; v.e_pc4 = ep4; v.e_valid = ev; v.e_state = es;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst_n            = v.rst_n;
    bus.i_start      = v.start;
    bus.i_step_mode  = v.smode;
    bus.i_step       = v.step;
    bus.i_stall      = v.stall;
    bus.i_flush      = v.flush;
    bus.i_pc_src     = v.pc_src;
    bus.i_target     = v.target;
    force_halt       = v.fh;
  endtask

  task automatic cmp(input string name, input logic [31:0] pc, input logic [31:0] ins,
                     input logic [31:0] p4, input logic v, input logic h, input logic [1:0] s,
                     input logic [31:0] epc, input logic [31:0] eins, input logic [31:0] ep4,
                     input logic ev, input logic [1:0] es);
    logic eh;
    eh = (es == 2'd2);
    checks++;
    if (pc !== epc || ins !== eins || p4 !== ep4 || v !== ev || h !== eh || s !== es) begin
      errors++;
      $display("FAIL %s: got pc=%h instr=%h pc4=%h v=%b h=%b st=%0d, exp pc=%h instr=%h pc4=%h v=%b h=%b st=%0d",
               name, pc, ins, p4, v, h, s, epc, eins, ep4, ev, eh, es);
    end
  endtask

  task automatic check_main(input string name, input logic [31:0] epc, input logic [31:0] eins,
                            input logic [31:0] ep4, input logic ev, input logic [1:0] es);
    cmp(name, bus.o_pc, bus.o_instr_id, bus.o_pc_plus4_id, bus.o_valid_id, bus.o_halted,
        bus.o_state, epc, eins, ep4, ev, es);
  endtask

  // One clock edge of the fetch stage as seen from outside, using current bus inputs.
  task automatic model_step();
    logic [31:0] cur, seq;
    if (!rst_n) begin
      m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_st = 0;
      return;
    end
    if (m_st == 0) begin
      if (bus.i_start) m_st = 1;
      return;
    end
    if (m_st == 2) return;
    if (bus.i_step_mode && !bus.i_step) return;
    if (bus.i_stall) return;
    cur = force_halt ? Halt : mem_word(m_pc);
    seq = m_pc + 32'd4;
    if (bus.i_flush) begin
      m_pc = bus.i_pc_src ? bus.i_target : seq;
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (cur == Halt) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0; m_st = 2;
    end else begin
      m_pc = bus.i_pc_src ? bus.i_target : seq;
      m_instr = cur; m_pc4 = seq; m_valid = 1;
    end
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0;
    rst_n_w = 1'b0;
    force_halt = 1'b0;
    bus_w.i_start = 0; bus_w.i_step_mode = 0; bus_w.i_step = 0; bus_w.i_stall = 0;
    bus_w.i_flush = 0; bus_w.i_pc_src = 0; bus_w.i_target = 0;

    //           rst st sm sp sl fl ps target        fh  e_pc          e_instr       e_pc4        v  st
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 32'h00, 32'h0,        32'h0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 32'h0,  0, 32'h00, 32'h0,        32'h0,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,  0, 32'h00, 32'h0,        32'h0,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h0,  0, 32'h00, 32'h0,        32'h0,  0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,  0, 32'h04, 32'h20080001, 32'h04, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,  0, 32'h08, 32'h20080401, 32'h08, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 32'h0,  0, 32'h08, 32'h20080401, 32'h08, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 32'h0,  0, 32'h08, 32'h20080401, 32'h08, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,  0, 32'h0C, 32'h20080801, 32'h0C, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'h40, 0, 32'h40, 32'h0,        32'h0,  0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,  0, 32'h44, 32'h20084001, 32'h44, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 1, 32'h80, 0, 32'h44, 32'h20084001, 32'h44, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'h80, 0, 32'h80, 32'h0,        32'h0,  0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h10, 0, 32'h10, 32'h20088001, 32'h84, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h50, 1, 32'h10, 32'h0,        32'h0,  0, 2));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 32'h40, 0, 32'h10, 32'h0,        32'h0,  0, 2));
    vecs.push_back(mk(1, 1, 1, 1, 0, 1, 1, 32'h40, 0, 32'h10, 32'h0,        32'h0,  0, 2));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 32'h40, 0, 32'h00, 32'h0,        32'h0,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h0,  0, 32'h00, 32'h0,        32'h0,  0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h20, 0, 32'h20, 32'h20080001, 32'h04, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 32'h0,  0, 32'h20, 32'h20080001, 32'h04, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 32'h0,  0, 32'h20, 32'h20080001, 32'h04, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1, 32'h99, 0, 32'h20, 32'h20080001, 32'h04, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 32'h0,  0, 32'h20, 32'h20080001, 32'h04, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 32'h0,  0, 32'h20, 32'h20080001, 32'h04, 1, 1));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 32'h0,  0, 32'h24, 32'h20082001, 32'h24, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 32'h0,  0, 32'h24, 32'h20082001, 32'h24, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,  0, 32'h28, 32'h20082401, 32'h28, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'h0,  0, 32'h2C, 32'h0,        32'h0,  0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,  0, 32'h30, 32'h20082C01, 32'h30, 1, 1));

    apply(vecs[0]);
    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      @(posedge clk); #1;
      check_main($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc4,
                 vecs[i].e_valid, vecs[i].e_state);
    end

    // Randomized run against the reference model; cycle 0 forces a reset.
    for (int i = 0; i < 3000; i++) begin
      rst_n           = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      bus.i_start     = ($urandom_range(0, 7) == 0);
      bus.i_step_mode = ($urandom_range(0, 3) == 0);
      bus.i_step      = $urandom_range(0, 1);
      bus.i_stall     = ($urandom_range(0, 3) == 0);
      bus.i_flush     = ($urandom_range(0, 5) == 0);
      bus.i_pc_src    = ($urandom_range(0, 4) == 0);
      bus.i_target    = ($urandom_range(0, 3) == 0) ? $urandom : {$urandom_range(0, 255), 2'b00};
      force_halt      = ($urandom_range(0, 59) == 0);
      model_step();
      @(posedge clk); #1;
      check_main($sformatf("rand%0d", i), m_pc, m_instr, m_pc4, m_valid, 2'(m_st));
    end

    // PC wrap from RESET_PC = 0xFFFFFFFC.
    rst_n_w = 1'b0;
    @(posedge clk); #1;
    cmp("wrap_reset", bus_w.o_pc, bus_w.o_instr_id, bus_w.o_pc_plus4_id, bus_w.o_valid_id,
        bus_w.o_halted, bus_w.o_state, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 2'd0);
    rst_n_w = 1'b1;
    bus_w.i_start = 1'b1;
    @(posedge clk); #1;
    cmp("wrap_start", bus_w.o_pc, bus_w.o_instr_id, bus_w.o_pc_plus4_id, bus_w.o_valid_id,
        bus_w.o_halted, bus_w.o_state, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 2'd1);
    bus_w.i_start = 1'b0;
    @(posedge clk); #1;
    cmp("wrap_adv", bus_w.o_pc, bus_w.o_instr_id, bus_w.o_pc_plus4_id, bus_w.o_valid_id,
        bus_w.o_halted, bus_w.o_state, 32'h0, mem_word(32'hFFFFFFFC), 32'h0, 1'b1, 2'd1);
    @(posedge clk); #1;
    cmp("wrap_next", bus_w.o_pc, bus_w.o_instr_id, bus_w.o_pc_plus4_id, bus_w.o_valid_id,
        bus_w.o_halted, bus_w.o_state, 32'h4, mem_word(32'h0), 32'h4, 1'b1, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
